dtfag_tw_mul_pipe: RTL and testbench
====================================

Name: dtfag_tw_mul_pipe

Overview:
- Parametrised twiddle-factor multiply pipeline for the DTFAG.
- Per channel, it takes the high-address and low-address ROM words and computes TF = (HA * LA) mod N_in.
- Supports CH parallel ROM banks, configurable multiplier depth, a per-channel bypass mode, pipeline stall, and a sideband tag.
- Sits between the DTFAG ROM banks and the radix-16 butterfly twiddle inputs.

Parameters:
- DW, 64, data/modulus width in bits (matches D_width).
- CH, 2, number of independent ROM-bank channels.
- MUL_STAGES, 3, register stages inside the modular multiplier; minimum 1.
- TAG_W, 8, sideband tag width carried alongside the data.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous and active-high; name is retained for codebase consistency, polarity is high.
- en  input  1  pipeline advance; when 0, every pipeline register holds.
- in_valid  input  1  input word set is valid this cycle.
- in_tag  input  TAG_W  sideband tag; delivered unmodified with the result.
- N_in  input  DW  modulus; sampled together with the operands.
- mode  input  2*CH  per-channel mode, 2 bits each: 0 = HA*LA mod N, 1 = HA pass, 2 = LA pass, 3 = constant 1.
- ha_in  input  CH*DW  packed HA ROM outputs; channel c occupies bits [c*DW +: DW].
- la_in  input  CH*DW  packed LA ROM outputs, same packing.
- out_valid  output  1  result valid.
- out_tag  output  TAG_W  tag aligned with the result.
- tf_out  output  CH*DW  packed twiddle results.

Behaviour:
- Latency: LAT = MUL_STAGES + 1 advancing cycles.
  - Stage 0 registers the inputs: operands, N_in, mode, tag, valid.
  - The following MUL_STAGES stages perform the multiply and reduction.
  - Split of multiply and reduction across stages is free; total depth is exactly MUL_STAGES.
- Throughput: one input set per advancing cycle. No back-pressure output; the upstream block drives en.
- en = 0:
  - All data, valid and tag registers hold.
  - Inputs presented while en = 0 are ignored.
  - Outputs stay stable.
- en = 1: every stage shifts by one.
  - valid is shifted too, so bubbles (in_valid = 0) propagate as out_valid = 0.
  - Data registers may load don't-care values on bubbles, but tf_out must still be deterministic: the register contents are whatever was loaded.
- Arithmetic:
  - Full 2*DW-bit product, reduced mod N_in.
  - Operands ≥ N_in are legal; the result is still (HA*LA) mod N_in, in range [0, N_in-1].
  - N_in = 0 or N_in = 1: result is 0 for mode 0.
  - Modes 1 and 2 pass the operand unreduced.
  - Mode 3 outputs 1 (zero-extended) regardless of N_in.
- Mode, N_in and tag are captured at stage 0 and travel with their data. Changing them mid-stream affects only words entered after the change.
- Channels are fully independent: the mode of channel c never affects channel c'.
- Reset (rst_n = 1 at a clock edge):
  - Clears every valid bit, out_valid = 0, out_tag = 0, tf_out = 0.
  - Takes priority over en.
  - Reset asserted mid-stream discards all in-flight words; none appear after reset deassertion.
- Reset deasserted while in_valid = 1 on the same edge: that word is not captured (reset wins). The first capture is on the next edge with en = 1.
- Simultaneous rst_n = 1 and en = 0: reset still clears.
- No combinational path from any input to any output.

Test Plan:
- Basic product, DW = 64, CH = 2, MUL_STAGES = 3, en = 1:
  - Stimulus: N_in = 0xFFFFFFFF00000001, ch0 HA = 2, LA = 3; ch1 HA = 0xFFFFFFFF00000000, LA = 2.
  - Response: exactly 4 cycles later, out_valid = 1; ch0 = 6; ch1 = 0xFFFFFFFEFFFFFFFF ((N-1)*2 mod N = N-2).
- Streaming:
  - Stimulus: 16 back-to-back valid sets with tags 0..15 and random operands < N.
  - Response: 16 consecutive out_valid pulses starting at cycle 4; tags in order 0..15; every result matches the reference model.
- Stall:
  - Stimulus: stream 8 sets; hold en = 0 for 5 cycles after the 3rd input.
  - Response: outputs frozen during the stall, no valid is lost or duplicated, tag order is preserved, and total completion is delayed by exactly 5 cycles.
- Modes and oversized operand, per channel:
  - Stimulus: ch0 mode = 1 and ch1 mode = 2 with HA = 0xAA, LA = 0x55; then both channels mode = 3; then mode = 0 with HA = N + 5, LA = 1.
  - Response: 0xAA / 0x55; then 1 / 1; then 5.
- Reset mid-operation:
  - Stimulus: 3 sets in flight, assert rst_n for 1 cycle, then feed 1 new set with tag 0x7E.
  - Response: out_valid = 0 and tf_out = 0 immediately after reset; none of the 3 old words appear; only tag 0x7E emerges, 4 cycles after its capture.
- Parameter sweep:
  - Stimulus: MUL_STAGES = 1 and 5, CH = 4, DW = 32, N_in = 0xFFFFFFFB, random stream with random bubbles.
  - Response: latency is 2 and 6 cycles respectively; all results match the model; bubbles are preserved in position.

Source files
------------

// File: rtl/dtfag_tw_mul_pipe.sv
//==============================================================================
// Module      : dtfag_tw_mul_pipe
// Description : Twiddle-factor multiply pipeline for the DTFAG. For each of CH
//               ROM-bank channels it forms TF = (HA * LA) mod N_in, or passes
//               HA / LA through, or emits constant 1, selected per channel by
//               a 2-bit mode. Mode, modulus and tag travel with their data.
//
// Ports       : clk       - clock, rising edge
//               rst_n     - synchronous reset, ACTIVE HIGH (legacy name)
//               en        - pipeline advance; 0 freezes every register
//               in_valid  - input word set valid
//               in_tag    - sideband tag, returned unmodified with the result
//               N_in      - modulus, captured with the operands
//               mode      - 2 bits per channel: 0 mul-mod, 1 HA, 2 LA, 3 one
//               ha_in     - packed HA words, channel c at [c*DW +: DW]
//               la_in     - packed LA words, same packing
//               out_valid - result valid
//               out_tag   - tag aligned with the result
//               tf_out    - packed twiddle results
//
// Latency     : MUL_STAGES + 1 advancing cycles.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dtfag_tw_mul_pipe #(
    parameter int DW         = 64,
    parameter int CH         = 2,
    parameter int MUL_STAGES = 3,
    parameter int TAG_W      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                in_valid,
    input  logic [TAG_W-1:0]    in_tag,
    input  logic [DW-1:0]       N_in,
    input  logic [2*CH-1:0]     mode,
    input  logic [CH*DW-1:0]    ha_in,
    input  logic [CH*DW-1:0]    la_in,
    output logic                out_valid,
    output logic [TAG_W-1:0]    out_tag,
    output logic [CH*DW-1:0]    tf_out
);

    localparam int c_PW = 2 * DW;

    // Final-stage select: pass-through modes keep the operand unreduced and
    // a modulus of 0 or 1 forces the product result to 0.
    function automatic logic [DW-1:0] f_reduce(
        input logic [c_PW-1:0] val,
        input logic [DW-1:0]   n,
        input logic            red
    );
        if (!red)
            f_reduce = val[DW-1:0];
        else if (n <= DW'(1))
            f_reduce = '0;
        else
            f_reduce = DW'(val % {{DW{1'b0}}, n});
    endfunction

    //--------------------------------------------------------------------------
    // Stage 0: input capture
    //--------------------------------------------------------------------------
    logic                r0_vld;
    logic [TAG_W-1:0]    r0_tag;
    logic [DW-1:0]       r0_n;
    logic [2*CH-1:0]     r0_mode;
    logic [CH*DW-1:0]    r0_ha;
    logic [CH*DW-1:0]    r0_la;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r0_vld  <= 1'b0;
            r0_tag  <= '0;
            r0_n    <= '0;
            r0_mode <= '0;
            r0_ha   <= '0;
            r0_la   <= '0;
        end else if (en) begin
            r0_vld  <= in_valid;
            r0_tag  <= in_tag;
            r0_n    <= N_in;
            r0_mode <= mode;
            r0_ha   <= ha_in;
            r0_la   <= la_in;
        end
    end

    // Mode decode: full-width product for mode 0, zero-extended operand or
    // constant otherwise. w_red marks channels that still need reduction.
    logic [CH-1:0][c_PW-1:0] w_pre;
    logic [CH-1:0]           w_red;

    always_comb begin
        for (int c = 0; c < CH; c++) begin
            w_red[c] = (r0_mode[2*c +: 2] == 2'd0);
            case (r0_mode[2*c +: 2])
                2'd0:    w_pre[c] = {{DW{1'b0}}, r0_ha[c*DW +: DW]} *
                                    {{DW{1'b0}}, r0_la[c*DW +: DW]};
                2'd1:    w_pre[c] = {{DW{1'b0}}, r0_ha[c*DW +: DW]};
                2'd2:    w_pre[c] = {{DW{1'b0}}, r0_la[c*DW +: DW]};
                default: w_pre[c] = {{(c_PW-1){1'b0}}, 1'b1};
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Valid / tag shift register, one entry per multiplier stage
    //--------------------------------------------------------------------------
    logic [MUL_STAGES-1:0] r_vld;
    logic [TAG_W-1:0]      r_tag [MUL_STAGES];

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_vld <= '0;
            for (int k = 0; k < MUL_STAGES; k++)
                r_tag[k] <= '0;
        end else if (en) begin
            r_vld[0] <= r0_vld;
            r_tag[0] <= r0_tag;
            for (int k = 1; k < MUL_STAGES; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    //--------------------------------------------------------------------------
    // Multiply / reduce datapath
    //--------------------------------------------------------------------------
    logic [CH-1:0][DW-1:0] w_tf;

    generate
        if (MUL_STAGES == 1) begin : g_single
            // Product and reduction share the only stage.
            logic [CH-1:0][DW-1:0] r_res;

            always_ff @(posedge clk) begin
                if (rst_n) begin
                    r_res <= '0;
                end else if (en) begin
                    for (int c = 0; c < CH; c++)
                        r_res[c] <= f_reduce(w_pre[c], r0_n, w_red[c]);
                end
            end

            assign w_tf = r_res;
        end else begin : g_multi
            // Stage 1 registers the product, stage 2 reduces, the remaining
            // stages are plain delay to reach the configured depth.
            logic [CH-1:0][c_PW-1:0] r_prod;
            logic [DW-1:0]           r_pn;
            logic [CH-1:0]           r_pred;
            logic [CH-1:0][DW-1:0]   r_res [MUL_STAGES-1];

            always_ff @(posedge clk) begin
                if (rst_n) begin
                    r_prod <= '0;
                    r_pn   <= '0;
                    r_pred <= '0;
                    for (int k = 0; k < MUL_STAGES-1; k++)
                        r_res[k] <= '0;
                end else if (en) begin
                    r_prod <= w_pre;
                    r_pn   <= r0_n;
                    r_pred <= w_red;
                    for (int c = 0; c < CH; c++)
                        r_res[0][c] <= f_reduce(r_prod[c], r_pn, r_pred[c]);
                    for (int k = 1; k < MUL_STAGES-1; k++)
                        r_res[k] <= r_res[k-1];
                end
            end

            assign w_tf = r_res[MUL_STAGES-2];
        end
    endgenerate

    assign out_valid = r_vld[MUL_STAGES-1];
    assign out_tag   = r_tag[MUL_STAGES-1];
    assign tf_out    = w_tf;

endmodule

`default_nettype wire

// File: tb/tb_dtfag_tw_mul_pipe.sv
//==============================================================================
// Module      : tb_dtfag_tw_mul_pipe
// Description : Scoreboard bench for dtfag_tw_mul_pipe. Three instances:
//               A (DW 64, CH 2, 3 mul stages), B and C (DW 32, CH 4, 1 and 5
//               mul stages) sharing one stimulus stream.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_dtfag_tw_mul_pipe;

    localparam logic [63:0] c_NA = 64'hFFFFFFFF00000001;
    localparam logic [31:0] c_NB = 32'hFFFFFFFB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, en;
    logic         a_vld;  logic [7:0] a_tag; logic [63:0] a_n; logic [3:0] a_mode;
    logic [127:0] a_ha, a_la;
    logic         a_ov;   logic [7:0] a_otag; logic [127:0] a_tf;
    logic         b_vld;  logic [7:0] b_tag; logic [31:0] b_n; logic [7:0] b_mode;
    logic [127:0] b_ha, b_la;
    logic         b_ov;   logic [7:0] b_otag; logic [127:0] b_tf;
    logic         c_ov;   logic [7:0] c_otag; logic [127:0] c_tf;

    dtfag_tw_mul_pipe #(.DW(64), .CH(2), .MUL_STAGES(3), .TAG_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(a_vld), .in_tag(a_tag),
        .N_in(a_n), .mode(a_mode), .ha_in(a_ha), .la_in(a_la),
        .out_valid(a_ov), .out_tag(a_otag), .tf_out(a_tf));

    dtfag_tw_mul_pipe #(.DW(32), .CH(4), .MUL_STAGES(1), .TAG_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(b_vld), .in_tag(b_tag),
        .N_in(b_n), .mode(b_mode), .ha_in(b_ha), .la_in(b_la),
        .out_valid(b_ov), .out_tag(b_otag), .tf_out(b_tf));

    dtfag_tw_mul_pipe #(.DW(32), .CH(4), .MUL_STAGES(5), .TAG_W(8)) u_c (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(b_vld), .in_tag(b_tag),
        .N_in(b_n), .mode(b_mode), .ha_in(b_ha), .la_in(b_la),
        .out_valid(c_ov), .out_tag(c_otag), .tf_out(c_tf));

    typedef struct {
        logic [7:0]   tag;
        logic [127:0] data;
        int           p;     // advancing edges seen when the word was presented
    } exp_t;

    exp_t qa[$], qb[$], qc[$];
    exp_t last_e [3];
    logic last_v [3] = '{default: 1'b0};

    int adv    = 0;   // count of advancing clock edges
    int kind   = 0;   // last edge: 0 reset, 1 advance, 2 hold
    int n_chk  = 0;
    int n_fail = 0;

    always @(posedge clk) begin
        kind <= rst_n ? 0 : (en ? 1 : 2);
        if (!rst_n && en) adv <= adv + 1;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // Reference: TF rules written directly as modular arithmetic.
    function automatic logic [63:0] ref_tf(input logic [1:0] m, input logic [63:0] n,
                                           input logic [63:0] ha, input logic [63:0] la);
        logic [127:0] prod;
        prod = 128'(ha) * 128'(la);
        case (m)
            2'd1:    return ha;
            2'd2:    return la;
            2'd3:    return 64'd1;
            default: return (n < 64'd2) ? 64'd0 : 64'(prod % 128'(n));
        endcase
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    //--------------------------------------------------------------------------
    // Monitor: pops on an advancing edge with out_valid, checks frozen outputs
    // on held edges.
    //--------------------------------------------------------------------------
    task automatic mon(input int id, input int lat, input logic v,
                       input logic [7:0] tg, input logic [127:0] d);
        exp_t e;
        int   sz;
        if (kind == 0) begin
            last_v[id] = 1'b0;
        end else if (kind == 1) begin
            if (v) begin
                sz = (id == 0) ? qa.size() : (id == 1) ? qb.size() : qc.size();
                if (sz == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL dut%0d_extra: out_valid with tag %h, none expected", id, tg);
                    last_v[id] = 1'b0;
                end else begin
                    case (id)
                        0:       e = qa.pop_front();
                        1:       e = qb.pop_front();
                        default: e = qc.pop_front();
                    endcase
                    chk($sformatf("dut%0d_tag", id), 128'(tg), 128'(e.tag));
                    chk($sformatf("dut%0d_data", id), d, e.data);
                    chk($sformatf("dut%0d_latency", id), 128'(adv - e.p), 128'(lat));
                    last_e[id] = e;
                    last_v[id] = 1'b1;
                end
            end else begin
                last_v[id] = 1'b0;
            end
        end else begin
            chk($sformatf("dut%0d_stall_valid", id), 128'(v), 128'(last_v[id]));
            if (last_v[id]) begin
                chk($sformatf("dut%0d_stall_tag", id), 128'(tg), 128'(last_e[id].tag));
                chk($sformatf("dut%0d_stall_data", id), d, last_e[id].data);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, 4, a_ov, a_otag, a_tf);
        mon(1, 2, b_ov, b_otag, b_tf);
        mon(2, 6, c_ov, c_otag, c_tf);
    end

    //--------------------------------------------------------------------------
    // Drivers: set inputs, record expectation if the word will be captured,
    // then step to just after the next rising edge.
    //--------------------------------------------------------------------------
    task automatic put_a(input logic v, input logic [7:0] tg, input logic [3:0] md,
                         input logic [63:0] n, input logic [127:0] ha, input logic [127:0] la,
                         input bit push, input bit hand, input logic [127:0] hexp);
        exp_t e;
        a_vld = v; a_tag = tg; a_mode = md; a_n = n; a_ha = ha; a_la = la;
        if (push && v && en && !rst_n) begin
            e.tag = tg;
            e.p   = adv;
            if (hand)
                e.data = hexp;
            else
                for (int c = 0; c < 2; c++)
                    e.data[c*64 +: 64] = ref_tf(md[2*c +: 2], n, ha[c*64 +: 64], la[c*64 +: 64]);
            qa.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic put_b(input logic v, input logic [7:0] tg, input logic [7:0] md,
                         input logic [31:0] n, input logic [127:0] ha, input logic [127:0] la);
        exp_t e;
        b_vld = v; b_tag = tg; b_mode = md; b_n = n; b_ha = ha; b_la = la;
        if (v && en && !rst_n) begin
            e.tag = tg;
            e.p   = adv;
            for (int c = 0; c < 4; c++)
                e.data[c*32 +: 32] = 32'(ref_tf(md[2*c +: 2], 64'(n),
                                                64'(ha[c*32 +: 32]), 64'(la[c*32 +: 32])));
            qb.push_back(e);
            qc.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        a_vld = 1'b0;
        b_vld = 1'b0;
        for (int i = 0; i < 40 && (qa.size() + qb.size() + qc.size()) != 0; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [127:0] rnd_a();
        return {rnd64() % c_NA, rnd64() % c_NA};
    endfunction

    initial begin
        rst_n = 1'b1; en = 1'b1;
        a_vld = 1'b0; a_tag = '0; a_n = '0; a_mode = '0; a_ha = '0; a_la = '0;
        b_vld = 1'b0; b_tag = '0; b_n = '0; b_mode = '0; b_ha = '0; b_la = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a_valid", 128'(a_ov), 128'(0));
        chk("rst_a_tag",   128'(a_otag), 128'(0));
        chk("rst_a_tf",    a_tf, 128'(0));
        chk("rst_b_valid", 128'(b_ov), 128'(0));
        chk("rst_b_tf",    b_tf, 128'(0));
        chk("rst_c_valid", 128'(c_ov), 128'(0));
        chk("rst_c_tf",    c_tf, 128'(0));

        // Word presented on the last reset edge must not be captured
        a_vld = 1'b1; a_tag = 8'h33; a_n = c_NA; a_ha = 128'd7; a_la = 128'd9;
        @(posedge clk);
        #1;
        rst_n = 1'b0;

        // Basic product
        put_a(1, 8'h01, 4'h0, c_NA, {64'hFFFFFFFF00000000, 64'd2}, {64'd2, 64'd3},
              1, 1, {64'hFFFFFFFEFFFFFFFF, 64'd6});
        drain();

        // Streaming, tags 0..15
        for (int i = 0; i < 16; i++)
            put_a(1, 8'(i), 4'h0, c_NA, rnd_a(), rnd_a(), 1, 0, '0);
        drain();

        // Stall for 5 cycles after the third input; inputs during stall ignored
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                en = 1'b0;
                repeat (5) put_a(1, 8'hEE, 4'h0, c_NA, rnd_a(), rnd_a(), 1, 0, '0);
                en = 1'b1;
            end
            put_a(1, 8'(8'h20 + i), 4'h0, c_NA, rnd_a(), rnd_a(), 1, 0, '0);
        end
        drain();

        // Modes, oversized operand, degenerate moduli
        put_a(1, 8'h40, 4'b1001, c_NA, {2{64'hAA}}, {2{64'h55}}, 1, 1, {64'h55, 64'hAA});
        put_a(1, 8'h41, 4'hF, 64'd0, rnd_a(), rnd_a(), 1, 1, {64'd1, 64'd1});
        put_a(1, 8'h42, 4'h0, c_NA, {2{c_NA + 64'd5}}, {2{64'd1}}, 1, 1, {64'd5, 64'd5});
        put_a(1, 8'h43, 4'h0, 64'd0, rnd_a(), rnd_a(), 1, 1, 128'd0);
        put_a(1, 8'h44, 4'h0, 64'd1, rnd_a(), rnd_a(), 1, 1, 128'd0);
        put_a(1, 8'h45, 4'b0101, c_NA, {c_NA + 64'd7, 64'hFFFFFFFFFFFFFFFF}, rnd_a(),
              1, 1, {c_NA + 64'd7, 64'hFFFFFFFFFFFFFFFF});
        put_a(0, 8'h46, 4'h0, c_NA, rnd_a(), rnd_a(), 1, 0, '0);
        for (int i = 0; i < 6; i++)
            put_a(1, 8'(8'h50 + i), 4'($urandom), c_NA, {rnd64(), rnd64()}, {rnd64(), rnd64()},
                  1, 0, '0);
        drain();

        // Reset mid-stream: three words in flight are discarded
        for (int i = 0; i < 3; i++)
            put_a(1, 8'(8'h60 + i), 4'h0, c_NA, rnd_a(), rnd_a(), 0, 0, '0);
        rst_n = 1'b1;
        a_vld = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_valid", 128'(a_ov), 128'(0));
        chk("midrst_tf",    a_tf, 128'(0));
        chk("midrst_tag",   128'(a_otag), 128'(0));
        rst_n = 1'b0;
        put_a(1, 8'h7E, 4'h0, c_NA, rnd_a(), rnd_a(), 1, 0, '0);
        drain();

        // Parameter sweep on B/C with random bubbles and modes
        for (int i = 0; i < 48; i++)
            put_b(($urandom_range(0, 3) != 0), 8'(i), 8'($urandom), c_NB,
                  {$urandom, $urandom, $urandom, $urandom},
                  {$urandom, $urandom, $urandom, $urandom});
        drain();

        chk("qa_empty", 128'(qa.size()), 128'(0));
        chk("qb_empty", 128'(qb.size()), 128'(0));
        chk("qc_empty", 128'(qc.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
